// File: rtl/keypad_scan_display_if.sv
// Signal bundle between the keypad/display pins and the keypad_scan_display scanner.
// valid_key has no ready: it is a one-cycle strobe that the consumer must take in that cycle; key and key_down are levels.
interface keypad_scan_display_if;
  logic [2:0] row;
  logic       display_enable;
  logic [2:0] column;
  logic [3:0] key;
  logic       valid_key;
  logic       key_down;
  logic [6:0] hex;
  logic [1:0] scan_state;

  modport master (
    output row, display_enable,
    input  column, key, valid_key, key_down, hex, scan_state
  );

  modport slave (
    input  row, display_enable,
    output column, key, valid_key, key_down, hex, scan_state
  );
endinterface

// File: rtl/keypad_scan_display.sv
// 3x3 keypad matrix scanner with frame debouncing and a seven-segment echo of the accepted key.
// scan_state exposes the column-strobe FSM.
module keypad_scan_display #(
  parameter int SCAN_DIV = 50_000,
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic reset,
  keypad_scan_display_if.slave bus
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [3:0] NO_KEY = 4'hF;

  typedef enum logic [1:0] {COL0, COL1, COL2} col_state_t;

  col_state_t    col_q, col_d;
  logic [DW-1:0] div_q;
  logic          tick;
  logic          frame_end;
  logic [8:0]    img_q, img_d;
  logic [3:0]    cand;
  logic [3:0]    prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic [3:0]    key_q;
  logic          valid_q;
  logic          down_q;

  assign tick      = (div_q == DW'(SCAN_DIV));
  assign frame_end = tick && (col_q == COL2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= '0;
      col_q <= COL0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      col_q <= col_d;
    end
  end

  always_comb begin
    col_d = col_q;
    if (tick) begin
      case (col_q)
        COL0:    col_d = COL1;
        COL1:    col_d = COL2;
        default: col_d = COL0;
      endcase
    end
  end

  // The strobed column's rows are captured at the tick that ends its settling period.
  always_comb begin
    img_d = img_q;
    if (tick) begin
      case (col_q)
        COL0: begin
          img_d[0] = ~bus.row[0];
          img_d[3] = ~bus.row[1];
          img_d[6] = ~bus.row[2];
        end
        COL1: begin
          img_d[1] = ~bus.row[0];
          img_d[4] = ~bus.row[1];
          img_d[7] = ~bus.row[2];
        end
        default: begin
          img_d[2] = ~bus.row[0];
          img_d[5] = ~bus.row[1];
          img_d[8] = ~bus.row[2];
        end
      endcase
    end
  end

  // Descending scan so the lowest pressed index is the one left standing.
  always_comb begin
    cand = NO_KEY;
    for (int i = 8; i >= 0; i--) begin
      if (img_d[i]) cand = 4'(i);
    end
  end

  always_comb begin
    if (cand == prev_q) cnt_d = (cnt_q < CW'(DEBOUNCE)) ? cnt_q + 1'b1 : cnt_q;
    else                cnt_d = CW'(1);
  end

  assign accept = (cnt_d == CW'(DEBOUNCE));

  always_ff @(posedge clk) begin
    if (!reset) begin
      img_q   <= '0;
      prev_q  <= NO_KEY;
      cnt_q   <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      img_q   <= img_d;
      valid_q <= 1'b0;
      if (frame_end) begin
        prev_q <= cand;
        cnt_q  <= cnt_d;
        if (accept) begin
          // A held key blocks any other key until a stable empty frame run releases it.
          if (cand == NO_KEY) begin
            down_q <= 1'b0;
          end else if (!down_q) begin
            key_q   <= cand;
            valid_q <= 1'b1;
            down_q  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    case (col_q)
      COL0:    bus.column = 3'b110;
      COL1:    bus.column = 3'b101;
      COL2:    bus.column = 3'b011;
      default: bus.column = 3'b110;
    endcase
  end

  always_comb begin
    bus.hex = 7'b1111111;
    if (bus.display_enable) begin
      case (key_q)
        4'd0:    bus.hex = 7'b1000000;
        4'd1:    bus.hex = 7'b1111001;
        4'd2:    bus.hex = 7'b0100100;
        4'd3:    bus.hex = 7'b0110000;
        4'd4:    bus.hex = 7'b0011001;
        4'd5:    bus.hex = 7'b0010010;
        4'd6:    bus.hex = 7'b0000010;
        4'd7:    bus.hex = 7'b1111000;
        4'd8:    bus.hex = 7'b0000000;
        4'd9:    bus.hex = 7'b0010000;
        default: bus.hex = 7'b1111111;
      endcase
    end
  end

  assign bus.key        = key_q;
  assign bus.valid_key  = valid_q;
  assign bus.key_down   = down_q;
  assign bus.scan_state = col_q;
endmodule

// File: tb/tb_keypad_scan_display.sv
// Directed bench for keypad_scan_display with a behavioural 3x3 key matrix on the row lines.
module tb_keypad_scan_display;
  logic clk;
  logic reset;
  logic [8:0] keys;
  int applied;
  int miscompares;
  int pulse_cnt;
  logic vk_prev;

  keypad_scan_display_if bus ();

  keypad_scan_display #(.SCAN_DIV(3), .DEBOUNCE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A row reads low when a pressed key sits on that row in the strobed column.
  function automatic logic [2:0] row_model(input logic [8:0] k, input logic [2:0] col);
    logic [2:0] r_out;
    logic [2:0] seg;
    for (int r = 0; r < 3; r++) begin
      seg = k[r*3 +: 3];
      r_out[r] = ~|(seg & ~col);
    end
    return r_out;
  endfunction

  assign bus.row = row_model(keys, bus.column);

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [8:0] keys;
    int         ncyc;
    logic [2:0] col;
    logic [3:0] key;
    logic       vk;
    logic       kd;
    logic [6:0] hex;
  } vec_t;

  vec_t vecs[14];

  // Driver task: advance one cycle and watch valid_key width on every cycle.
  task automatic step();
    @(negedge clk);
    if (bus.valid_key && vk_prev) begin
      miscompares++;
      $display("FAIL valid_key_width: got high 2 cycles in a row, want single-cycle pulse");
    end
    vk_prev = bus.valid_key;
    if (bus.valid_key) pulse_cnt++;
  endtask

  task automatic check_out(input string name, input logic [2:0] col, input logic [3:0] key,
                           input logic vk, input logic kd, input logic [6:0] hex);
    applied++;
    if (bus.column !== col || bus.key !== key || bus.valid_key !== vk ||
        bus.key_down !== kd || bus.hex !== hex) begin
      miscompares++;
      $display("FAIL %s: got col=%b key=%0d vk=%b kd=%b hex=%b, want col=%b key=%0d vk=%b kd=%b hex=%b",
               name, bus.column, bus.key, bus.valid_key, bus.key_down, bus.hex,
               col, key, vk, kd, hex);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    applied++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    keys  = '0;
    repeat (5) step();
    reset = 1'b1;
    pulse_cnt = 0;
  endtask

  initial begin
    int first_k;
    logic kd_seen;
    applied     = 0;
    miscompares = 0;
    pulse_cnt   = 0;
    vk_prev     = 1'b0;
    reset       = 1'b0;
    keys        = '0;
    bus.display_enable = 1'b1;

    // k counts clock edges after reset release; frames end at k = 12, 24, 36, ...
    vecs[0]  = '{1'b0, 1'b1, 9'h000,  5, 3'b110, 4'd0, 1'b0, 1'b0, 7'b1000000};
    vecs[1]  = '{1'b0, 1'b0, 9'h000,  1, 3'b110, 4'd0, 1'b0, 1'b0, 7'b1111111};
    vecs[2]  = '{1'b1, 1'b1, 9'h000,  3, 3'b110, 4'd0, 1'b0, 1'b0, 7'b1000000};
    vecs[3]  = '{1'b1, 1'b1, 9'h000,  1, 3'b101, 4'd0, 1'b0, 1'b0, 7'b1000000};
    vecs[4]  = '{1'b1, 1'b1, 9'h000,  3, 3'b101, 4'd0, 1'b0, 1'b0, 7'b1000000};
    vecs[5]  = '{1'b1, 1'b1, 9'h000,  1, 3'b011, 4'd0, 1'b0, 1'b0, 7'b1000000};
    vecs[6]  = '{1'b1, 1'b1, 9'h000,  3, 3'b011, 4'd0, 1'b0, 1'b0, 7'b1000000};
    vecs[7]  = '{1'b1, 1'b1, 9'h000,  1, 3'b110, 4'd0, 1'b0, 1'b0, 7'b1000000};
    vecs[8]  = '{1'b1, 1'b1, 9'h020, 23, 3'b011, 4'd0, 1'b0, 1'b0, 7'b1000000};
    vecs[9]  = '{1'b1, 1'b1, 9'h020,  1, 3'b110, 4'd5, 1'b1, 1'b1, 7'b0010010};
    vecs[10] = '{1'b1, 1'b1, 9'h020,  1, 3'b110, 4'd5, 1'b0, 1'b1, 7'b0010010};
    vecs[11] = '{1'b1, 1'b1, 9'h000, 22, 3'b011, 4'd5, 1'b0, 1'b1, 7'b0010010};
    vecs[12] = '{1'b1, 1'b1, 9'h000,  1, 3'b110, 4'd5, 1'b0, 1'b0, 7'b0010010};
    vecs[13] = '{1'b1, 1'b0, 9'h000,  1, 3'b110, 4'd5, 1'b0, 1'b0, 7'b1111111};

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst_n;
      bus.display_enable = vecs[i].en;
      keys = vecs[i].keys;
      for (int c = 0; c < vecs[i].ncyc; c++) step();
      check_out($sformatf("vec%0d", i), vecs[i].col, vecs[i].key,
                vecs[i].vk, vecs[i].kd, vecs[i].hex);
    end
    bus.display_enable = 1'b1;

    // Key 7 held for 10 frames: exactly one pulse, at the end of frame 2.
    do_reset();
    keys = 9'h080;
    first_k = -1;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (bus.valid_key && first_k < 0) first_k = k;
    end
    check_val("hold7_pulses", pulse_cnt, 1);
    check_val("hold7_latency", first_k, 24);
    check_out("hold7_end", 3'b110, 4'd7, 1'b0, 1'b1, 7'b1111000);

    // Key 3 present for a single frame only: rejected by debounce.
    do_reset();
    keys = 9'h008;
    kd_seen = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      if (k == 13) keys = '0;
      step();
      if (bus.key_down) kd_seen = 1'b1;
    end
    check_val("bounce3_pulses", pulse_cnt, 0);
    check_val("bounce3_keydown", int'(kd_seen), 0);
    check_out("bounce3_end", 3'b110, 4'd0, 1'b0, 1'b0, 7'b1000000);

    // Keys 2 and 6 together: lowest index wins.
    do_reset();
    keys = 9'h044;
    repeat (23) step();
    check_out("prio_k23", 3'b011, 4'd0, 1'b0, 1'b0, 7'b1000000);
    step();
    check_out("prio_k24", 3'b110, 4'd2, 1'b1, 1'b1, 7'b0100100);

    // Reset in the middle of the next frame, keys released with it.
    repeat (6) step();
    reset = 1'b0;
    keys  = '0;
    repeat (2) step();
    check_out("midreset", 3'b110, 4'd0, 1'b0, 1'b0, 7'b1000000);
    reset = 1'b1;
    pulse_cnt = 0;
    kd_seen = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (bus.key_down) kd_seen = 1'b1;
    end
    check_val("midreset_pulses", pulse_cnt, 0);
    check_val("midreset_keydown", int'(kd_seen), 0);
    check_out("midreset_end", 3'b110, 4'd0, 1'b0, 1'b0, 7'b1000000);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/keypad_scan_display.md
# keypad_scan_display

Scanned 3×3 keypad front end with seven-segment echo for the whack-a-mole game. A programmable clock divider paces a column-strobing matrix scanner. The scanner debounces the row inputs and reports the pressed key index (0–8) with a one-cycle `valid_key` pulse and a held `key_down` level. A binary-to-seven-segment decoder drives one HEX digit with the current key code. The game FSM consumes `key`/`valid_key`; `hex` goes directly to a display.

## Interface
- `SCAN_DIV`, default 50_000: divider terminal count; one scan tick every `SCAN_DIV`+1 clk cycles (1 ms at 50 MHz). Minimum 1.
- `DEBOUNCE`, default 2: number of consecutive identical scan frames required to accept a press or release. Minimum 1.
- `clk` in 1: single system clock (CLOCK_50); all state on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `row` in 3: keypad row sense, active-low (externally pulled up).
- `display_enable` in 1: 1 = show key on `hex`, 0 = blank.
- `column` out 3: column strobe, active-low one-hot.
- `key` out 4: last accepted key index = row*3 + col (0–8).
- `valid_key` out 1: one-cycle pulse when a new key is accepted.
- `key_down` out 1: debounced "a key is held" level.
- `hex` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **Divider:** counter runs 0..`SCAN_DIV` and wraps to 0. A scan tick is asserted in the cycle the counter equals `SCAN_DIV`.
- **Column strobe:** column index c cycles 0→1→2→0, advancing on each tick. `column` = ~(1<<c), so exactly one bit is low.
- **Row sampling:**
  - On each tick, before advancing c, sample `row` for column c into the 9-bit frame image.
  - Bit index r*3+c is set when `row[r]`==0.
  - Each sample is taken after a full tick period of settling.
- **Frame:** completes on the tick that samples c=2. Frame candidate = lowest set index in the image, or "none" if no bit is set.
- **Debounce:** a candidate equal to the previous frame's candidate increments the stable count; a different candidate reloads the count to 1. When the count reaches `DEBOUNCE`:
  - Candidate is a key and `key_down`==0: `key` ← candidate, `valid_key` pulses for 1 cycle, `key_down` ← 1.
  - Candidate is a key and `key_down`==1: no change. A different held key is not reported until all keys are released.
  - Candidate is "none": `key_down` ← 0; `key` retains its value.
- **Simultaneous keys:** lowest index wins, per the frame-candidate rule.
- **`hex` decode:**
  - Combinational from `key` and `display_enable`.
  - Digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Codes 10–15, or `display_enable`=0: 1111111 (blank).
- **Reset (`reset`=0 at a clk edge):**
  - Divider count = 0, c = 0, so `column` = 3'b110.
  - Frame image, previous candidate and stable count cleared; previous candidate = "none".
  - `key` = 0, `valid_key` = 0, `key_down` = 0.
  - `hex` then shows "0" if enabled.
- **Reset mid-frame:** partial frame is discarded; no pulse is generated.

## Timing
- Tick period: `SCAN_DIV`+1 cycles. Frame: 3 ticks. First tick after reset release: `SCAN_DIV` cycles later.
- `column` changes in the cycle after the tick edge. Samples are registered at the tick edge.
- `valid_key`, `key_down` and `key` update together, registered one cycle after the frame-completing tick.
- **Press latency:** a press held from a frame boundary yields `valid_key` at the end of frame `DEBOUNCE`.
- **Release latency:** `key_down` falls after `DEBOUNCE` empty frames.
- `hex` has no added latency relative to `key`.
- `valid_key` is never high for more than 1 consecutive cycle.

## Test plan
Settings: `SCAN_DIV`=3, `DEBOUNCE`=2.
1. **Reset:** hold `reset`=0 for 5 cycles → `column`=110, `key`=0, `valid_key`=0, `key_down`=0, `hex`=1000000; with `display_enable`=0, `hex`=1111111.
2. **Scan order:** no keys pressed → `column` sequence 110, 101, 011, 110, each held 4 cycles; `valid_key` stays 0.
3. **Single press:** model key 5 (row 1, col 2), pulling `row[1]` low while `column`[2]=0 → after 2 frames (24 cycles) one `valid_key` pulse, `key`=5, `key_down`=1, `hex`=0010010.
4. **Release and hold:** release key 5 → `key_down`=0 after 2 empty frames, `key` stays 5. Key 7 held 10 frames → exactly one `valid_key`.
5. **Debounce:** key 3 present for 1 frame only, then none → no `valid_key`, `key_down` stays 0.
6. **Priority and reset:** keys 2 and 6 pressed together → `key`=2. Assert `reset` mid-frame → all outputs return to reset values; no pulse.
